instr_control_unit: RTL

INSTR_CONTROL_UNIT -- requirements
Module: instr_control_unit

---
 rtl/instr_control_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_control_unit.sv
// Multi-cycle instruction control unit: fetches 16-bit instructions, decodes
// the opcode into datapath controls and sequences FETCH/DECODE/EXEC/MEM/WB.
// Illegal opcodes park the unit in a sticky HALT state that only reset clears.
module instr_control_unit (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [15:0] Instruction,
    output logic [2:0]  opcode,
    output logic        RegDst,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;

    // Static controls packed as {RegDst, ALUSrc, MemToReg, ALUOp[1:0]}.
    function automatic logic [4:0] decode_static(input logic [2:0] op);
        logic [4:0] ctl;
        case (op)
            OP_R:    ctl = 5'b10010;
            OP_ADDI: ctl = 5'b01000;
            OP_LW:   ctl = 5'b01100;
            OP_SW:   ctl = 5'b01000;
            OP_BEQ:  ctl = 5'b00001;
            OP_J:    ctl = 5'b00000;
            default: ctl = 5'b00000;
        endcase
        return ctl;
    endfunction

    state_t      state_r;
    logic [15:0] pc_r;
    logic [15:0] instr_r;
    logic        imem_req_r;
    logic        reg_dst_r;
    logic        branch_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        reg_write_r;
    logic        mem_to_reg_r;
    logic        alu_src_r;
    logic [1:0]  alu_op_r;
    logic        halted_r;

    logic [2:0]  op_s;
    logic [15:0] branch_target_s;
    logic [15:0] jump_target_s;

    // Decode helpers derived from the instruction register and current pc.
    always_comb begin
        op_s            = instr_r[15:13];
        branch_target_s = pc_r + {{9{instr_r[6]}}, instr_r[6:0]};
        jump_target_s   = {pc_r[15:13], instr_r[12:0]};
    end

    // Main sequencer: state, pc, instruction register and all registered controls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_FETCH;
            pc_r         <= 16'h0000;
            instr_r      <= 16'h0000;
            imem_req_r   <= 1'b0;
            reg_dst_r    <= 1'b0;
            branch_r     <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            alu_src_r    <= 1'b0;
            alu_op_r     <= 2'b00;
            halted_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // The request is raised one cycle after entering FETCH from
                    // reset, so an ack is only honoured while it is visible.
                    if (imem_req_r && imem_ack) begin
                        instr_r    <= imem_data;
                        pc_r       <= pc_r + 16'd1;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_DECODE;
                        {reg_dst_r, alu_src_r, mem_to_reg_r, alu_op_r} <= decode_static(imem_data[15:13]);
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (op_s[2:1] == 2'b11) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                        {reg_dst_r, alu_src_r, mem_to_reg_r, alu_op_r} <= 5'b00000;
                    end else begin
                        state_r  <= ST_EXEC;
                        branch_r <= (op_s == OP_BEQ);
                    end
                end
                ST_EXEC: begin
                    case (op_s)
                        OP_R, OP_ADDI: begin
                            state_r     <= ST_WB;
                            reg_write_r <= 1'b1;
                        end
                        OP_LW: begin
                            state_r    <= ST_MEM;
                            mem_read_r <= 1'b1;
                        end
                        OP_SW: begin
                            state_r     <= ST_MEM;
                            mem_write_r <= 1'b1;
                        end
                        OP_BEQ, OP_J: begin
                            if (op_s == OP_J) begin
                                pc_r <= jump_target_s;
                            end else if (alu_zero) begin
                                pc_r <= branch_target_s;
                            end else begin
                                pc_r <= pc_r;
                            end
                            branch_r   <= 1'b0;
                            imem_req_r <= 1'b1;
                            state_r    <= ST_FETCH;
                            {reg_dst_r, alu_src_r, mem_to_reg_r, alu_op_r} <= 5'b00000;
                        end
                        default: begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                            branch_r <= 1'b0;
                            {reg_dst_r, alu_src_r, mem_to_reg_r, alu_op_r} <= 5'b00000;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        if (op_s == OP_LW) begin
                            state_r     <= ST_WB;
                            reg_write_r <= 1'b1;
                        end else begin
                            state_r    <= ST_FETCH;
                            imem_req_r <= 1'b1;
                            {reg_dst_r, alu_src_r, mem_to_reg_r, alu_op_r} <= 5'b00000;
                        end
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WB: begin
                    reg_write_r <= 1'b0;
                    imem_req_r  <= 1'b1;
                    state_r     <= ST_FETCH;
                    {reg_dst_r, alu_src_r, mem_to_reg_r, alu_op_r} <= 5'b00000;
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
                default: begin
                    // Corrupted state encoding: stop safely with every strobe low.
                    state_r     <= ST_HALT;
                    halted_r    <= 1'b1;
                    imem_req_r  <= 1'b0;
                    branch_r    <= 1'b0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    reg_write_r <= 1'b0;
                    {reg_dst_r, alu_src_r, mem_to_reg_r, alu_op_r} <= 5'b00000;
                end
            endcase
        end
    end

    assign imem_addr   = pc_r;
    assign imem_req    = imem_req_r;
    assign Instruction = instr_r;
    assign opcode      = instr_r[15:13];
    assign RegDst      = reg_dst_r;
    assign Branch      = branch_r;
    assign MemRead     = mem_read_r;
    assign MemWrite    = mem_write_r;
    assign RegWrite    = reg_write_r;
    assign MemToReg    = mem_to_reg_r;
    assign ALUSrc      = alu_src_r;
    assign ALUOp       = alu_op_r;
    assign pc          = pc_r;
    assign halted      = halted_r;

endmodule
